// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: decodes a spike train into a per-window spike count and last inter-spike interval.
// Interval tracking exists only when SPIKE_RATE_DECODER_ISI_EN is defined; otherwise isi reads 0.
module spike_rate_decoder #(
  parameter int WIN_CYCLES = 256,
  parameter int CNT_W      = 8,
  parameter int ISI_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] rate,
  output logic [ISI_W-1:0] isi,
  output logic             overflow,
  output logic             valid,
  input  logic             ready
);

  localparam int IDX_W = $clog2(WIN_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_win_idx;
  logic [CNT_W-1:0] r_spk_cnt;
  logic             r_ovf_acc;
  logic [CNT_W-1:0] r_rate;
  logic             r_overflow;
  logic             r_valid;

  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  // MSB of the result flags an increment lost to saturation.
  function automatic logic [CNT_W:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return {1'b1, c};
    return {1'b0, c + CNT_W'(1)};
  endfunction

  assign w_cnt_inc = cnt_sat_inc(r_spk_cnt);

`ifdef SPIKE_RATE_DECODER_ISI_EN
  localparam logic [63:0] ISI_MAX = (64'd1 << ISI_W) - 64'd1;

  logic             r_seen;
  logic [IDX_W-1:0] r_prev_idx;
  logic [ISI_W-1:0] r_isi_last;
  logic [ISI_W-1:0] r_isi;
  logic [ISI_W:0]   w_isi_sat;
  logic [ISI_W-1:0] w_isi_nxt;

  // Interval is measured at full index width, then clamped to the isi width.
  function automatic logic [ISI_W:0] isi_sat(input logic [IDX_W-1:0] d);
    if (64'(d) > ISI_MAX) return {1'b1, {ISI_W{1'b1}}};
    return {1'b0, ISI_W'(d)};
  endfunction

  assign w_isi_sat = isi_sat(r_win_idx - r_prev_idx);
  assign isi       = r_isi;
`else
  assign isi = '0;
`endif

  always_comb begin
    w_cnt_nxt = r_spk_cnt;
    w_ovf_nxt = r_ovf_acc;
    if (spike) begin
      w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
      w_ovf_nxt = r_ovf_acc | w_cnt_inc[CNT_W];
    end
`ifdef SPIKE_RATE_DECODER_ISI_EN
    w_isi_nxt = r_isi_last;
    if (spike && r_seen) begin
      w_isi_nxt = w_isi_sat[ISI_W-1:0];
      w_ovf_nxt = w_ovf_nxt | w_isi_sat[ISI_W];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_win_idx  <= '0;
      r_spk_cnt  <= '0;
      r_ovf_acc  <= 1'b0;
      r_rate     <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
`ifdef SPIKE_RATE_DECODER_ISI_EN
      r_seen     <= 1'b0;
      r_prev_idx <= '0;
      r_isi_last <= '0;
      r_isi      <= '0;
`endif
    end else begin
      // Outside COUNT the window accumulators sit cleared, so every entry to COUNT starts fresh.
      if (r_state != S_COUNT) begin
        r_win_idx <= '0;
        r_spk_cnt <= '0;
        r_ovf_acc <= 1'b0;
`ifdef SPIKE_RATE_DECODER_ISI_EN
        r_seen     <= 1'b0;
        r_prev_idx <= '0;
        r_isi_last <= '0;
`endif
      end
      case (r_state)
        S_IDLE: begin
          if (en) r_state <= S_COUNT;
        end
        S_COUNT: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else begin
            r_spk_cnt <= w_cnt_nxt;
            r_ovf_acc <= w_ovf_nxt;
`ifdef SPIKE_RATE_DECODER_ISI_EN
            r_isi_last <= w_isi_nxt;
            if (spike) begin
              r_seen     <= 1'b1;
              r_prev_idx <= r_win_idx;
            end
`endif
            if (r_win_idx == LAST_IDX) begin
              r_state    <= S_HOLD;
              r_rate     <= w_cnt_nxt;
              r_overflow <= w_ovf_nxt;
              r_valid    <= 1'b1;
`ifdef SPIKE_RATE_DECODER_ISI_EN
              r_isi      <= w_isi_nxt;
`endif
            end else begin
              r_win_idx <= r_win_idx + IDX_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (ready) begin
            r_valid <= 1'b0;
            r_state <= en ? S_COUNT : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rate     = r_rate;
  assign overflow = r_overflow;
  assign valid    = r_valid;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: directed scenarios plus random windows checked against a
// spike-position reference model; isi expectations follow SPIKE_RATE_DECODER_ISI_EN.
module tb_spike_rate_decoder;

  localparam int WIN  = 16;
  localparam int CW   = 3;
  localparam int IW   = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam int IMAX = (1 << IW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          spike = 1'b0;
  logic          ready = 1'b0;
  logic [CW-1:0] rate;
  logic [IW-1:0] isi;
  logic          overflow;
  logic          valid;

  int n_vec = 0;
  int n_err = 0;

  logic [CW-1:0] exp_rate;
  logic [IW-1:0] exp_isi;
  logic          exp_ovf;

  spike_rate_decoder #(.WIN_CYCLES(WIN), .CNT_W(CW), .ISI_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spike(spike),
    .rate(rate), .isi(isi), .overflow(overflow), .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: list the spike positions of a window, then count and take gaps between neighbours.
  task automatic model(input logic [WIN-1:0] pat);
    int pos[$];
    int n;
    logic ovf;
    for (int i = 0; i < WIN; i++) if (pat[i]) pos.push_back(i);
    n = pos.size();
    exp_rate = CW'((n > CMAX) ? CMAX : n);
    ovf = (n > CMAX);
    exp_isi = '0;
`ifdef SPIKE_RATE_DECODER_ISI_EN
    for (int j = 1; j < n; j++) begin
      int gap;
      gap = pos[j] - pos[j-1];
      if (gap > IMAX) ovf = 1'b1;
      exp_isi = IW'((gap > IMAX) ? IMAX : gap);
    end
`endif
    exp_ovf = ovf;
  endtask

  function automatic logic [WIN-1:0] rand_pat();
    logic [WIN-1:0] a, b;
    a = WIN'($urandom);
    b = WIN'($urandom);
    case ($urandom_range(0, 3))
      0: return a & b;
      1: return a | b;
      2: return a & b & WIN'($urandom);
      default: return a;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; spike = 1'b1; ready = 1'b0;
    tick(); tick();
    n_vec++;
    if ({valid, overflow, isi, rate} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0", {valid, overflow, isi, rate});
    end
    rst_n = 1'b1; en = 1'b0; spike = 1'b0;
    tick(); tick();
    n_vec++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_valid: got %b want 0", valid);
    end
  endtask

  task automatic test_basic();
    logic [WIN-1:0] pat = 16'h1111;
    model(pat);
    en = 1'b1; ready = 1'b1;
    tick();
    for (int k = 0; k < WIN; k++) begin
      spike = pat[k];
      tick();
      if (k == WIN - 2) begin
        n_vec++;
        if (valid !== 1'b0) begin
          n_err++;
          $display("FAIL basic_early_valid: got %b want 0", valid);
        end
      end
    end
    n_vec++;
    if ({valid, overflow, isi, rate} !== {1'b1, exp_ovf, exp_isi, exp_rate}) begin
      n_err++;
      $display("FAIL basic_result: got %b want %b", {valid, overflow, isi, rate}, {1'b1, exp_ovf, exp_isi, exp_rate});
    end
    spike = 1'b0; en = 1'b0;
    tick();
    n_vec++;
    if ({valid, overflow, isi, rate} !== {1'b0, exp_ovf, exp_isi, exp_rate}) begin
      n_err++;
      $display("FAIL basic_transfer: got %b want %b", {valid, overflow, isi, rate}, {1'b0, exp_ovf, exp_isi, exp_rate});
    end
  endtask

  task automatic test_saturation();
    logic [WIN-1:0] pat = '1;
    model(pat);
    en = 1'b1; ready = 1'b1;
    tick();
    for (int k = 0; k < WIN; k++) begin
      spike = pat[k];
      tick();
    end
    n_vec++;
    if ({valid, overflow, isi, rate} !== {1'b1, exp_ovf, exp_isi, exp_rate}) begin
      n_err++;
      $display("FAIL sat_result: got %b want %b", {valid, overflow, isi, rate}, {1'b1, exp_ovf, exp_isi, exp_rate});
    end
    spike = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_hold_stall();
    logic [WIN-1:0] pat;
    pat = rand_pat();
    model(pat);
    en = 1'b1; ready = 1'b0;
    tick();
    for (int k = 0; k < WIN; k++) begin
      spike = pat[k];
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      spike = c[0];
      tick();
      n_vec++;
      if ({valid, overflow, isi, rate} !== {1'b1, exp_ovf, exp_isi, exp_rate}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got %b want %b", c, {valid, overflow, isi, rate}, {1'b1, exp_ovf, exp_isi, exp_rate});
      end
    end
    ready = 1'b1; en = 1'b1; spike = 1'b1;
    tick();
    n_vec++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_transfer_valid: got %b want 0", valid);
    end
    pat = 16'h0020;
    model(pat);
    for (int k = 0; k < WIN; k++) begin
      spike = pat[k];
      tick();
    end
    n_vec++;
    if ({valid, overflow, isi, rate} !== {1'b1, exp_ovf, exp_isi, exp_rate}) begin
      n_err++;
      $display("FAIL stall_next_window: got %b want %b", {valid, overflow, isi, rate}, {1'b1, exp_ovf, exp_isi, exp_rate});
    end
    spike = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    logic [CW+IW:0] keep;
    keep = {exp_ovf, exp_isi, exp_rate};
    en = 1'b1; ready = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      spike = (k == 1 || k == 3 || k == 5);
      tick();
    end
    en = 1'b0; spike = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      spike = 1'($urandom);
      tick();
      if (c % 4 == 3) begin
        n_vec++;
        if ({valid, overflow, isi, rate} !== {1'b0, keep}) begin
          n_err++;
          $display("FAIL abort_idle[%0d]: got %b want %b", c, {valid, overflow, isi, rate}, {1'b0, keep});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; ready = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      spike = 1'($urandom);
      tick();
    end
    rst_n = 1'b0; spike = 1'b1;
    tick();
    n_vec++;
    if ({valid, overflow, isi, rate} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b want 0", {valid, overflow, isi, rate});
    end
    rst_n = 1'b1; en = 1'b1; spike = 1'b0;
    model('0);
    tick();
    for (int k = 0; k < WIN; k++) begin
      spike = 1'b0;
      tick();
    end
    n_vec++;
    if ({valid, overflow, isi, rate} !== {1'b1, exp_ovf, exp_isi, exp_rate}) begin
      n_err++;
      $display("FAIL midreset_next: got %b want %b", {valid, overflow, isi, rate}, {1'b1, exp_ovf, exp_isi, exp_rate});
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [WIN-1:0] pat;
    bit cont = 1'b0;
    for (int w = 0; w < 40; w++) begin
      pat = rand_pat();
      model(pat);
      if (!cont) begin
        en = 1'b1; spike = 1'($urandom); ready = 1'($urandom);
        tick();
      end
      for (int k = 0; k < WIN; k++) begin
        spike = pat[k]; ready = 1'($urandom);
        tick();
        if (k == WIN - 2) begin
          n_vec++;
          if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL rand_early_valid[%0d]: got %b want 0", w, valid);
          end
        end
      end
      n_vec++;
      if ({valid, overflow, isi, rate} !== {1'b1, exp_ovf, exp_isi, exp_rate}) begin
        n_err++;
        $display("FAIL rand_result[%0d] pat=%h: got %b want %b", w, pat, {valid, overflow, isi, rate}, {1'b1, exp_ovf, exp_isi, exp_rate});
      end
      ready = 1'b0;
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        spike = 1'($urandom); en = 1'($urandom);
        tick();
        n_vec++;
        if ({valid, overflow, isi, rate} !== {1'b1, exp_ovf, exp_isi, exp_rate}) begin
          n_err++;
          $display("FAIL rand_stall[%0d]: got %b want %b", w, {valid, overflow, isi, rate}, {1'b1, exp_ovf, exp_isi, exp_rate});
        end
      end
      cont = 1'($urandom);
      en = cont; ready = 1'b1; spike = 1'($urandom);
      tick();
      n_vec++;
      if ({valid, overflow, isi, rate} !== {1'b0, exp_ovf, exp_isi, exp_rate}) begin
        n_err++;
        $display("FAIL rand_transfer[%0d]: got %b want %b", w, {valid, overflow, isi, rate}, {1'b0, exp_ovf, exp_isi, exp_rate});
      end
    end
    en = 1'b0; ready = 1'b1; spike = 1'b0;
    repeat (WIN + 2) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_hold_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receiving end of the neuron spike interface. Consumes a single-bit spike train, for example from the LIF neuron output, and decodes it back into numeric values.
- Per fixed-length window it reports two values:
  - rate: the spike count over the window.
  - isi: the last inter-spike interval.
- Results leave through a valid/ready handshake, so downstream logic (STDP update, readout to IO) can stall.

Parameters:
- WIN_CYCLES, 256, window length in clk cycles; legal range 2..65536.
- CNT_W, 8, width of the spike counter and of rate.
- ISI_W, 8, width of the interval counter and of isi.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  decoding enable; sampled every cycle.
- spike  input  1  spike pulse; one spike per high cycle (no edge detection).
- rate  output  CNT_W  spike count of the last completed window.
- isi  output  ISI_W  cycles between the last two spikes of the last completed window.
- overflow  output  1  the rate or isi counter saturated during the reported window.
- valid  output  1  rate, isi and overflow hold a new result.
- ready  input  1  consumer accepts the result while valid=1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE.
  - rate, isi, overflow and valid go to 0.
  - All internal counters and flags are cleared.
  - Reset has priority in every state and aborts a window in progress.
- States: IDLE, COUNT, HOLD.
- IDLE:
  - Spikes are ignored.
  - en=1 moves to COUNT and clears win_idx, spk_cnt, isi_run, isi_last, seen_spike and ovf_acc.
  - The cycle after en is sampled high is window index 0.
- COUNT, each cycle at index win_idx (0..WIN_CYCLES-1):
  - spike=1 increments spk_cnt, saturating at 2^CNT_W-1. An increment attempted at saturation sets ovf_acc.
  - spike=1 with seen_spike=1 latches isi_last = win_idx - index of the previous spike, saturating at 2^ISI_W-1 (saturation sets ovf_acc), then records the current index.
  - spike=1 with seen_spike=0 sets seen_spike and records the index; isi_last is unchanged.
  - en=0 aborts to IDLE: no result, valid stays 0, and outputs keep the previous result.
  - At win_idx=WIN_CYCLES-1, a spike on that cycle is counted. The block then moves to HOLD and registers rate=spk_cnt, isi=isi_last, overflow=ovf_acc and valid=1.
  - valid therefore rises exactly WIN_CYCLES cycles after the first COUNT cycle.
- HOLD:
  - valid=1 and all outputs are stable.
  - Spikes are ignored and not counted into either window.
  - A transfer occurs on a cycle with valid=1 and ready=1; valid drops next cycle.
  - On transfer with en=1, go to COUNT with window index 0 on the next cycle (one dead cycle between windows).
  - On transfer with en=0, go to IDLE.
  - en=0 without ready stays in HOLD; the result is never discarded except by reset.
  - ready while valid=0 has no effect.
- Boundary values:
  - No spikes in a window: rate=0, isi=0.
  - Exactly one spike: rate=1, isi=0.
  - Spikes on consecutive cycles: isi=1.
- rate, isi and overflow change only on the cycle valid rises, or on reset.
- The interval counter is internal, sized to cover WIN_CYCLES, and is compared against the saturation limit.

Optional Feature:
- Macro SPIKE_RATE_DECODER_ISI_EN.
- Defined: the interval tracking and isi output behave as specified above.
- Undefined:
  - The interval logic is removed and isi is held at 0 permanently.
  - overflow reflects only spike-count saturation.
  - rate, valid and handshake timing are identical to the defined case.

Test Plan:
- WIN_CYCLES=16; en=1, ready=1; spike at indices 0,4,8,12 -> valid pulses for 1 cycle, 16 cycles after the first COUNT cycle; rate=4, isi=4, overflow=0.
- WIN_CYCLES=16, CNT_W=3; spike held high for all 16 cycles -> rate=7, isi=1, overflow=1.
- WIN_CYCLES=16; ready=0 for 10 cycles after valid rises; spikes toggling during HOLD -> outputs stable, valid held high. After ready=1 the next window counts only post-HOLD spikes: spike only at index 5 -> rate=1, isi=0.
- WIN_CYCLES=16; en dropped at index 7 after 3 spikes -> block returns to IDLE, no valid, rate/isi keep their previous values.
- WIN_CYCLES=16; rst_n=0 at index 10 mid-window, then re-enabled with no spikes -> all outputs 0 immediately after reset; the next result is rate=0, isi=0.
- Build without SPIKE_RATE_DECODER_ISI_EN, stimulus as in the first scenario -> rate=4, isi=0, same valid timing.
